// File: rtl/countdown_timer.sv
// Loadable down-counter with a clock prescaler, run/pause control and an expiry flag.
// Optional build macro: COUNTDOWN_AUTORELOAD_EN restarts the count from the last loaded value on expiry.
module countdown_timer #(
    parameter int n        = 10,
    parameter int TICK_DIV = 50000
) (
    input  logic         CLOCK_50,
    input  logic         Reset,
    input  logic         Load,
    input  logic [n-1:0] Value,
    input  logic         Go,
    output logic [n-1:0] Count,
    output logic         Running,
    output logic         Done,
    output logic         Expire
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESCALE_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [n-1:0]   count_nxt;
    logic [n-1:0]   reload;
    logic [n-1:0]   reload_nxt;
    logic [PW-1:0]  prescale;
    logic [PW-1:0]  prescale_nxt;
    logic           go_prev;
    logic           go_event;
    logic           tick;
    logic           expire_nxt;

    assign go_event = Go & ~go_prev;
    assign tick     = (state == RUN) && (prescale == PRESCALE_MAX);

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state    <= IDLE;
            Count    <= '0;
            reload   <= '0;
            prescale <= '0;
            go_prev  <= 1'b0;
            Running  <= 1'b0;
            Done     <= 1'b0;
            Expire   <= 1'b0;
        end else begin
            state    <= state_nxt;
            Count    <= count_nxt;
            reload   <= reload_nxt;
            prescale <= prescale_nxt;
            go_prev  <= Go;
            Running  <= (state_nxt == RUN);
            Done     <= (state_nxt == DONE);
            Expire   <= expire_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        count_nxt    = Count;
        reload_nxt   = reload;
        prescale_nxt = prescale;
        expire_nxt   = 1'b0;

        if (Load) begin
            count_nxt    = Value;
            reload_nxt   = Value;
            prescale_nxt = '0;
            state_nxt    = IDLE;
        end else if (go_event) begin
            // A go event pre-empts a coincident tick: the pause keeps the count as is.
            case (state)
                IDLE: begin
                    if (Count != '0) begin
                        state_nxt    = RUN;
                        prescale_nxt = '0;
                    end
                end
                RUN:     state_nxt = PAUSED;
                PAUSED:  state_nxt = RUN;
                default: state_nxt = state;
            endcase
        end else if (state == RUN) begin
            if (tick) begin
                prescale_nxt = '0;
                if (Count == n'(1)) begin
                    expire_nxt = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                    if (reload != '0) begin
                        count_nxt = reload;
                    end else begin
                        count_nxt = '0;
                        state_nxt = DONE;
                    end
`else
                    count_nxt = '0;
                    state_nxt = DONE;
`endif
                end else if (Count != '0) begin
                    count_nxt = Count - n'(1);
                end
            end else begin
                prescale_nxt = prescale + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer (n=4, TICK_DIV=4): directed plan steps plus a random phase,
// compared each cycle against an elapsed-run-time reference model.
module tb_countdown_timer;

    localparam int N = 4;
    localparam int T = 4;

    logic         CLOCK_50 = 1'b0;
    logic         Reset    = 1'b1;
    logic         Load     = 1'b0;
    logic [N-1:0] Value    = '0;
    logic         Go       = 1'b0;
    logic [N-1:0] Count;
    logic         Running;
    logic         Done;
    logic         Expire;

    countdown_timer #(.n(N), .TICK_DIV(T)) dut (
        .CLOCK_50 (CLOCK_50),
        .Reset    (Reset),
        .Load     (Load),
        .Value    (Value),
        .Go       (Go),
        .Count    (Count),
        .Running  (Running),
        .Done     (Done),
        .Expire   (Expire)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;

    // Reference model: count derived from cycles spent running since the last load.
    int m_val     = 0;
    int m_elapsed = 0;
    bit m_running = 0;
    bit m_paused  = 0;
    bit m_done    = 0;
    bit m_expire  = 0;
    bit m_go_prev = 0;

    int n_exp = 0;
    int n_run = 0;
    bit prev_running = 0;

    function automatic int m_count();
        if (m_done || m_val == 0) return 0;
        return m_val - (m_elapsed % (m_val * T)) / T;
    endfunction

    task automatic model_update(input bit rst, input bit ld, input int val, input bit g);
        bit go_ev;
        go_ev     = g && !m_go_prev;
        m_go_prev = rst ? 1'b0 : g;
        m_expire  = 0;
        if (rst) begin
            m_val = 0; m_elapsed = 0; m_running = 0; m_paused = 0; m_done = 0;
        end else if (ld) begin
            m_val = val; m_elapsed = 0; m_running = 0; m_paused = 0; m_done = 0;
        end else if (go_ev) begin
            if (m_running) begin
                m_running = 0; m_paused = 1;
            end else if (m_paused) begin
                m_running = 1; m_paused = 0;
            end else if (!m_done && m_count() != 0) begin
                m_running = 1;
            end
        end else if (m_running) begin
            m_elapsed++;
            if (m_elapsed % (m_val * T) == 0) begin
                m_expire = 1;
`ifndef COUNTDOWN_AUTORELOAD_EN
                m_running = 0;
                m_done    = 1;
`endif
            end
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit ld, input int val, input bit g);
        Reset = rst;
        Load  = ld;
        Value = N'(val);
        Go    = g;
        @(posedge CLOCK_50);
        model_update(rst, ld, val, g);
        #1;
        chk("count",   int'(Count),   m_count());
        chk("running", int'(Running), int'(m_running));
        chk("done",    int'(Done),    int'(m_done));
        chk("expire",  int'(Expire),  int'(m_expire));
        if (Expire === 1'b1) n_exp++;
        if (Running === 1'b1 && !prev_running) n_run++;
        prev_running = (Running === 1'b1);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        // Reset
        step(1, 0, 0, 0);
        step(1, 0, 9, 1);
        chk("reset_count", int'(Count), 0);
        step(0, 0, 0, 0);

        // Basic countdown from 3
        step(0, 1, 3, 0);
        chk("load_latency", int'(Count), 3);
        n_exp = 0;
        step(0, 0, 0, 1);
        chk("go_latency", int'(Running), 1);
        idle(11);
        chk("basic_before_expire", int'(Expire), 0);
        step(0, 0, 0, 0);
        chk("basic_expire_at_12", int'(Expire), 1);
        idle(4);
        chk("basic_expire_once", n_exp, 1);
`ifndef COUNTDOWN_AUTORELOAD_EN
        chk("basic_done", int'(Done), 1);
        chk("basic_stopped", int'(Running), 0);
`endif

        // Pause and resume from 5
        step(0, 1, 5, 0);
        step(0, 0, 0, 1);
        idle(6);
        step(0, 0, 0, 1);
        chk("pause_running", int'(Running), 0);
        idle(20);
        chk("pause_frozen", int'(Count), 4);
        step(0, 0, 0, 1);
        chk("resume_running", int'(Running), 1);
        step(0, 0, 0, 0);
        chk("resume_plus1", int'(Count), 4);
        step(0, 0, 0, 0);
        chk("resume_plus2", int'(Count), 3);
        idle(14);

        // Held Go gives one request
        step(0, 1, 2, 0);
        n_run = 0;
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
        chk("held_go_entries", n_run, 1);
        step(0, 0, 0, 0);

        // Load 0 then go: stays idle
        step(0, 1, 0, 0);
        n_exp = 0;
        step(0, 0, 0, 1);
        idle(6);
        chk("zero_idle", int'(Running), 0);
        chk("zero_no_expire", n_exp, 0);

        // Go on the tick cycle pauses without decrement
        step(0, 1, 3, 0);
        step(0, 0, 0, 1);
        idle(3);
        step(0, 0, 0, 1);
        chk("tick_go_paused", int'(Running), 0);
        chk("tick_go_count", int'(Count), 3);

        // Load and go together: idle
        step(0, 1, 5, 1);
        step(0, 0, 0, 0);
        chk("load_go_idle", int'(Running), 0);
        chk("load_go_count", int'(Count), 5);

        // Reset mid-run
        step(0, 1, 7, 0);
        step(0, 0, 0, 1);
        idle(9);
        step(1, 0, 0, 0);
        chk("rst_count", int'(Count), 0);
        chk("rst_running", int'(Running), 0);
        idle(6);
        chk("rst_stays_idle", int'(Running), 0);

`ifdef COUNTDOWN_AUTORELOAD_EN
        // Auto-reload from 2: expire every 8 cycles
        step(0, 1, 2, 0);
        n_exp = 0;
        step(0, 0, 0, 1);
        idle(40);
        chk("autoreload_expires", n_exp, 5);
        chk("autoreload_no_done", int'(Done), 0);
`endif

        // Random phase
        begin
            bit g;
            g = 0;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 5) == 0) g = ~g;
                step($urandom_range(0, 149) == 0, $urandom_range(0, 39) == 0,
                     int'($urandom_range(0, 15)), g);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
